// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder. Direct mode decodes handshaked codes;
// scan mode walks the one-hot bit from 0 to a programmable last index with a dwell time.
module onehot_scan_decoder #(
  parameter int CODE_W  = 4,
  parameter int DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CODE_W-1:0]        code,
  input  logic [CODE_W-1:0]        last,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [(1<<CODE_W)-1:0]   data,
  output logic [CODE_W-1:0]        index,
  output logic                     wrap
);

  localparam int OUT_W = 1 << CODE_W;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             state, state_nx;
  logic [OUT_W-1:0]   data_nx;
  logic [CODE_W-1:0]  index_nx;
  logic               wrap_nx;
  logic [DWELL_W-1:0] dcnt, dcnt_nx;

  function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] idx);
    logic [OUT_W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  assign in_ready = (state == DIRECT);

  always_comb begin
    state_nx = state;
    data_nx  = data;
    index_nx = index;
    wrap_nx  = 1'b0;
    dcnt_nx  = '0;
    case (state)
      IDLE: begin
        data_nx  = '0;
        index_nx = '0;
        if (en) begin
          if (mode) begin
            state_nx = SCAN;
            data_nx  = onehot('0);
          end else begin
            state_nx = DIRECT;
          end
        end
      end
      DIRECT: begin
        if (!en) begin
          state_nx = IDLE;
          data_nx  = '0;
          index_nx = '0;
        end else if (mode) begin
          state_nx = SCAN;
          data_nx  = onehot('0);
          index_nx = '0;
        end else if (in_valid) begin
          data_nx  = onehot(code);
          index_nx = code;
        end
      end
      SCAN: begin
        if (!en) begin
          state_nx = IDLE;
          data_nx  = '0;
          index_nx = '0;
        end else if (!mode) begin
          // Leaving scan clears the output; direct mode starts blank until an accept.
          state_nx = DIRECT;
          data_nx  = '0;
          index_nx = '0;
        end else if (dcnt == dwell) begin
          if (index >= last) begin
            index_nx = '0;
            wrap_nx  = 1'b1;
          end else begin
            index_nx = index + 1'b1;
          end
          data_nx = onehot(index_nx);
        end else begin
          // Counter wraps naturally if dwell was lowered below it mid-scan.
          dcnt_nx = dcnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        data_nx  = '0;
        index_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      index <= '0;
      wrap  <= 1'b0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      data  <= data_nx;
      index <= index_nx;
      wrap  <= wrap_nx;
      dcnt  <= dcnt_nx;
    end
  end

endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Registered, parametrised binary-to-one-hot decoder with two modes. Direct mode decodes codes accepted over a valid/ready handshake. Scan mode auto-sequences the one-hot output from 0 up to a programmable last index, holding each index for a programmable dwell time. It drives strobes and selects, such as register-file write enables and multiplexed display digit selects, where the combinational 4-to-16 decoder has no enable, no registering and no sequencing.

## Interface
- CODE_W, 4, code width; output width is 2**CODE_W (CODE_W in 1..6)
- DWELL_W, 8, width of the dwell-count input
- clk  input  1  rising-edge clock, single domain
- rst_n  input  1  reset, synchronous, active-low
- en  input  1  block enable; low forces IDLE and an all-zero output
- mode  input  1  0 = direct decode, 1 = scan
- in_valid  input  1  direct mode: code is valid
- in_ready  output  1  direct mode: block accepts code; high exactly when state is DIRECT
- code  input  CODE_W  direct-mode code
- last  input  CODE_W  scan mode: highest index visited
- dwell  input  DWELL_W  scan mode: each index is held dwell+1 cycles
- data  output  2**CODE_W  registered one-hot output, or all zero
- index  output  CODE_W  registered binary index of the asserted bit; 0 when data is zero
- wrap  output  1  one-cycle pulse when scan returns from last to 0

## Operation
- States: IDLE, DIRECT, SCAN. All outputs are registered except in_ready, which is decoded from state.
- IDLE:
  - data=0, index=0, wrap=0.
  - When en=1, next state is DIRECT if mode=0, else SCAN.
- DIRECT:
  - On an edge with in_valid & in_ready: data <= 1<<code, index <= code.
  - Without an accept, data and index hold; on first entry they hold 0 until the first accept.
- SCAN:
  - On entry: data <= 1, index <= 0, dwell counter <= 0, wrap <= 0.
  - Dwell counter increments each cycle. When it equals dwell, it clears and the index advances.
  - Advance rule: if index >= last, then index <= 0 and wrap <= 1; otherwise index <= index+1.
  - data always equals 1<<index while in SCAN.
  - wrap is 0 on every other cycle.
- Mode change while en=1:
  - DIRECT->SCAN goes through the SCAN entry action next edge.
  - SCAN->DIRECT goes to DIRECT with data=0 and index=0.
  - The dwell counter is cleared in both cases.
- en=0 in any state: next edge goes to IDLE; data=0, index=0, wrap=0, dwell counter cleared.
- Reset (rst_n=0 at an edge):
  - State IDLE, data=0, index=0, wrap=0, dwell counter=0.
  - in_ready=0 after that edge.
  - Reset wins over all other inputs, including mid-scan and mid-handshake.

## Timing
- Direct-mode latency: a code accepted at edge N appears on data/index after edge N, one cycle.
- in_ready is high every cycle in DIRECT, so throughput is one code per cycle.
- IDLE->DIRECT/SCAN takes one edge after en rises:
  - in_ready rises after that edge.
  - In SCAN, data=1 after that same edge.
- Scan period:
  - Each index is held exactly dwell+1 cycles; dwell=0 advances every cycle.
  - A full cycle is (last+1)*(dwell+1) cycles.
  - wrap is high in the first cycle of index 0 after each wrap, not on initial entry.
- last=0: index stays 0, data=1, and wrap pulses every dwell+1 cycles.
- last changed mid-scan: the new value applies at the next advance. If index already exceeds the new last, that advance wraps to 0.
- dwell changed mid-scan: the new value is compared from the next cycle. If the counter already exceeds the new dwell, it runs until it wraps modulo 2**DWELL_W.
- Exactly one bit of data is set in DIRECT after the first accept and in SCAN; no bit is set in IDLE.

## Test plan
- Reset then direct decode, CODE_W=4: rst_n low 2 cycles -> data=0, index=0, in_ready=0. Then en=1, mode=0 -> in_ready=1 after 1 edge. Send codes 0x0, 0x5, 0xF on consecutive cycles -> data=0x0001, 0x0020, 0x8000 one cycle after each, index matching.
- Direct hold: in_valid=0 with code toggling -> data stays at the last accepted value for 10 cycles.
- Scan with last=3, dwell=2 -> index sequence 0,0,0,1,1,1,2,2,2,3,3,3,0... and data 0x1,0x2,0x4,0x8. wrap high only on the cycle index returns to 0, i.e. every 12 cycles.
- Scan edge cases:
  - last=0, dwell=0 -> data=0x0001 constant, wrap high every cycle after the first.
  - last=15, dwell=0 -> full walk, wrap every 16 cycles.
- Mid-operation changes:
  - While scanning at index 9, set last=4 -> next advance gives index 0 with wrap=1.
  - Drop en -> data=0 after 1 edge.
  - Assert rst_n=0 mid-scan -> data=0, index=0, in_ready=0 after the edge.
- Mode switch: SCAN at index 2 -> mode=0 -> after 1 edge data=0 and in_ready=1. Accept code 0x7 -> data=0x0080.
